useq_controller: RTL and testbench
==================================

Name: useq_controller

Overview:
- Hardwired microsequencer that drives the 32-bit register-file/ALU datapath: register directions A/B/C, mux selects, ALU operation and the RD (memory-to-register) select.
- Runs fetch/decode/execute for a SPARC-subset ISA and owns the external memory request/acknowledge handshake, with a timeout watchdog.
- Holds the architectural PSR flags (N, Z, V, C), latched from the datapath ALU flag outputs.
- Sits between the datapath and the memory/bus interface.

Parameters:
- DATAWIDTH_MIR_DIRECTION, 6, width of DirA/DirB/DirC.
- DATAWIDTH_ALU_SELECTION, 4, width of the ALU operation code.
- DATAWIDTH_DECODEROP, 8, width of the decoded opcode from the IR.
- MEM_TIMEOUT, 16, maximum wait cycles for memory acknowledge; range 1..255.

Ports:
- USEQ_CLOCK_50  in  1  single system clock, rising edge.
- USEQ_RESET_InLow  in  1  asynchronous, active-low reset.
- USEQ_DecodeOP_InBus  in  8  {op[1:0], op3[5:0]}; for op=00, bits [4:1] = cond.
- USEQ_IR13_In  in  1  immediate flag.
- USEQ_IRrd_InBus  in  5  rd field, used as the store-data source.
- USEQ_FlagN_In / FlagZ_In / FlagV_In / FlagC_In  in  1 each  ALU flag outputs of the datapath.
- USEQ_MemAck_In  in  1  memory acknowledge.
- USEQ_DirA_OutBus / DirB_OutBus / DirC_OutBus  out  6 each  register directions.
- USEQ_SelectA_Out / SelectB_Out / SelectC_Out  out  1 each  1 = use Dir bus, 0 = use IR field.
- USEQ_ALUOperation_OutBus  out  4  ALU operation.
- USEQ_RD_Out  out  1  1 = C bus takes memory data.
- USEQ_MemReq_Out  out  1  memory request; address is the A bus.
- USEQ_MemWrite_Out  out  1  1 = write, data is the B bus.
- USEQ_PSR_OutBus  out  4  {N, Z, V, C}.
- USEQ_Fault_Out  out  1  sticky memory-timeout fault.
- USEQ_Illegal_Out  out  1  one-cycle pulse on an unsupported opcode.

Behaviour:
- Reset (asynchronous, active-low): state FETCH, PSR=0, watchdog=0, Fault=0, Illegal=0. All outputs are 0 except DirA=PC with SelectA=1.
- Register map: PC=R15, IR=R14, TEMP=R13. R0=0 and R1=1 are fixed.
- Writeback rule: DirC/SelectC are meaningful only while a write is intended. In all other states DirC=R0, and writes to R0 are discarded by the datapath.
- FETCH: MemReq=1, A=PC.
  - When Ack=1: RD=1, SelectC=1, DirC=IR; IR is written on that edge; go to DECODE.
  - Req is held until Ack. Ack while Req=0 is ignored.
- DECODE: one cycle, then dispatch on op:
  - op=10 with op3 in {ADD 000000, AND 000001, OR 000010, ADDCC 010000, ANDCC 010001, ORCC 010010} -> EXEC.
  - op=11 with op3=000000 (LD) or 000100 (ST) -> ADDR.
  - op=00 -> BRANCH.
  - Anything else -> Illegal pulse, then PCINC.
- EXEC (1 cycle): SelectA/B/C=0; B is rs2 or simm13 per IR13. ALU codes: ADD=0, AND=1, OR=2, ADDCC=3, ANDCC=4, ORCC=5. For cc ops, PSR latches the flag inputs at the end of this cycle. Go to PCINC.
- ADDR (1 cycle): ALU ADD, SelectA/B=0, DirC=TEMP, SelectC=1. Go to MEMW.
- MEMW: MemReq=1, A=TEMP.
  - LD: on Ack, RD=1, SelectC=0 (rd).
  - ST: MemWrite=1, DirB={0,rd}, SelectB=1.
  - On Ack go to PCINC.
- BRANCH (1 cycle): cond 1000 = always; 0001 = Z; 1001 = !Z; 0011 = N^V; 1011 = !(N^V); 0101 = C; 1101 = !C; other conds = never.
  - Taken: A=PC, ALU ADDD22=4'hA (PC + sext(disp22)<<2), C=PC; go to FETCH.
  - Not taken: go to PCINC.
- PCINC (1 cycle): A=PC, ALU INC4=4'hB, C=PC, SelectA/SelectC=1. Go to FETCH.
- Watchdog:
  - Counts cycles with Req=1 and Ack=0; clears on Ack or when leaving the wait state.
  - Reaching MEM_TIMEOUT: go to FAULT and set Fault=1. FAULT is terminal: all outputs idle, exit only by reset.
- Ack and timeout in the same cycle: Ack wins.
- Reset asserted mid-access: Req drops immediately (asynchronous); no partial writes occur.

Decomposition:
- Package useq_pkg holds:
  - state enum;
  - ALU code constants (ADD..ORCC, ADDD22, INC4);
  - register indices PC/IR/TEMP/R0;
  - op/op3/cond constants.
- One sub-module, useq_cond_eval: combinational branch-condition evaluator (cond, PSR) -> taken.

Test Plan:
- Reset low, then high; Ack returned after 2 cycles -> Req=1 from the first cycle, DirA=15, SelectA=1. On Ack: RD=1, DirC=14, SelectC=1. DECODE follows.
- DecodeOP=0x90 (ADDCC), flags N=1, Z=0, V=0, C=1 -> EXEC drives ALU=3 with SelectA/B/C=0; PSR=4'b1001 next cycle. PCINC then drives ALU=0xB, DirA=DirC=15.
- LD (0xC0): Ack after 3 cycles -> ADDR writes DirC=13. MEMW holds Req=1 and MemWrite=0 until Ack, then RD=1, SelectC=0.
- ST (0xC4), rd=5 -> MemWrite=1, DirB=6'd5, SelectB=1 until Ack.
- Branch BE (cond 0001): with Z=1 -> ALU=0xA, DirC=15, then FETCH. With Z=0 -> PCINC.
- Ack withheld, MEM_TIMEOUT=16 -> Fault=1 after 16 request cycles and stays 1. Subsequent Ack is ignored. A reset pulse clears Fault and restarts at FETCH.

Source files
------------

// File: rtl/useq_pkg.sv
// Shared types and constants for the hardwired microsequencer.
// Holds the state encoding, ALU codes, register indices and ISA fields.
package useq_pkg;

   localparam int DATAWIDTH_MIR_DIRECTION = 6;
   localparam int DATAWIDTH_ALU_SELECTION = 4;
   localparam int DATAWIDTH_DECODEROP     = 8;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_ADDR,
      ST_MEMW,
      ST_BRANCH,
      ST_PCINC,
      ST_FAULT
   } state_t;

   localparam logic [3:0] ALU_ADD    = 4'h0;
   localparam logic [3:0] ALU_AND    = 4'h1;
   localparam logic [3:0] ALU_OR     = 4'h2;
   localparam logic [3:0] ALU_ADDCC  = 4'h3;
   localparam logic [3:0] ALU_ANDCC  = 4'h4;
   localparam logic [3:0] ALU_ORCC   = 4'h5;
   localparam logic [3:0] ALU_ADDD22 = 4'hA;
   localparam logic [3:0] ALU_INC4   = 4'hB;

   localparam logic [5:0] REG_R0   = 6'd0;
   localparam logic [5:0] REG_TEMP = 6'd13;
   localparam logic [5:0] REG_IR   = 6'd14;
   localparam logic [5:0] REG_PC   = 6'd15;

   localparam logic [1:0] OP_BRANCH = 2'b00;
   localparam logic [1:0] OP_ARITH  = 2'b10;
   localparam logic [1:0] OP_MEM    = 2'b11;

   localparam logic [5:0] OP3_ADD   = 6'b000000;
   localparam logic [5:0] OP3_AND   = 6'b000001;
   localparam logic [5:0] OP3_OR    = 6'b000010;
   localparam logic [5:0] OP3_ADDCC = 6'b010000;
   localparam logic [5:0] OP3_ANDCC = 6'b010001;
   localparam logic [5:0] OP3_ORCC  = 6'b010010;
   localparam logic [5:0] OP3_LD    = 6'b000000;
   localparam logic [5:0] OP3_ST    = 6'b000100;

   localparam logic [3:0] COND_A  = 4'b1000;
   localparam logic [3:0] COND_E  = 4'b0001;
   localparam logic [3:0] COND_NE = 4'b1001;
   localparam logic [3:0] COND_L  = 4'b0011;
   localparam logic [3:0] COND_GE = 4'b1011;
   localparam logic [3:0] COND_CS = 4'b0101;
   localparam logic [3:0] COND_CC = 4'b1101;

   function automatic logic is_arith_op3(input logic [5:0] op3);
      return op3 inside {OP3_ADD, OP3_AND, OP3_OR, OP3_ADDCC, OP3_ANDCC, OP3_ORCC};
   endfunction

   function automatic logic [3:0] alu_code(input logic [5:0] op3);
      case (op3)
         OP3_AND:   return ALU_AND;
         OP3_OR:    return ALU_OR;
         OP3_ADDCC: return ALU_ADDCC;
         OP3_ANDCC: return ALU_ANDCC;
         OP3_ORCC:  return ALU_ORCC;
         default:   return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/useq_if.sv
// Sequencer <-> datapath/memory signal bundle.
// master = sequencer side, slave = datapath and memory side.
interface useq_if import useq_pkg::*; ();

   logic [DATAWIDTH_DECODEROP-1:0]     USEQ_DecodeOP_InBus;
   logic                               USEQ_IR13_In;
   logic [4:0]                         USEQ_IRrd_InBus;
   logic                               USEQ_FlagN_In;
   logic                               USEQ_FlagZ_In;
   logic                               USEQ_FlagV_In;
   logic                               USEQ_FlagC_In;
   logic                               USEQ_MemAck_In;
   logic [DATAWIDTH_MIR_DIRECTION-1:0] USEQ_DirA_OutBus;
   logic [DATAWIDTH_MIR_DIRECTION-1:0] USEQ_DirB_OutBus;
   logic [DATAWIDTH_MIR_DIRECTION-1:0] USEQ_DirC_OutBus;
   logic                               USEQ_SelectA_Out;
   logic                               USEQ_SelectB_Out;
   logic                               USEQ_SelectC_Out;
   logic [DATAWIDTH_ALU_SELECTION-1:0] USEQ_ALUOperation_OutBus;
   logic                               USEQ_RD_Out;
   logic                               USEQ_MemReq_Out;
   logic                               USEQ_MemWrite_Out;
   logic [3:0]                         USEQ_PSR_OutBus;
   logic                               USEQ_Fault_Out;
   logic                               USEQ_Illegal_Out;

   modport master (
      input  USEQ_DecodeOP_InBus, USEQ_IR13_In, USEQ_IRrd_InBus,
             USEQ_FlagN_In, USEQ_FlagZ_In, USEQ_FlagV_In, USEQ_FlagC_In, USEQ_MemAck_In,
      output USEQ_DirA_OutBus, USEQ_DirB_OutBus, USEQ_DirC_OutBus,
             USEQ_SelectA_Out, USEQ_SelectB_Out, USEQ_SelectC_Out,
             USEQ_ALUOperation_OutBus, USEQ_RD_Out, USEQ_MemReq_Out, USEQ_MemWrite_Out,
             USEQ_PSR_OutBus, USEQ_Fault_Out, USEQ_Illegal_Out
   );

   modport slave (
      output USEQ_DecodeOP_InBus, USEQ_IR13_In, USEQ_IRrd_InBus,
             USEQ_FlagN_In, USEQ_FlagZ_In, USEQ_FlagV_In, USEQ_FlagC_In, USEQ_MemAck_In,
      input  USEQ_DirA_OutBus, USEQ_DirB_OutBus, USEQ_DirC_OutBus,
             USEQ_SelectA_Out, USEQ_SelectB_Out, USEQ_SelectC_Out,
             USEQ_ALUOperation_OutBus, USEQ_RD_Out, USEQ_MemReq_Out, USEQ_MemWrite_Out,
             USEQ_PSR_OutBus, USEQ_Fault_Out, USEQ_Illegal_Out
   );

endinterface

// File: rtl/useq_cond_eval.sv
// Branch-condition evaluator: SPARC icc condition against PSR {N,Z,V,C}.
module useq_cond_eval import useq_pkg::*; (
   input  logic [3:0] i_cond,
   input  logic [3:0] i_psr,
   output logic       o_taken
);

   logic w_n, w_z, w_v, w_c;
   assign {w_n, w_z, w_v, w_c} = i_psr;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      o_taken = 1'b0;
      case (i_cond)
         COND_A:  o_taken = 1'b1;
         COND_E:  o_taken = w_z;
         COND_NE: o_taken = ~w_z;
         COND_L:  o_taken = w_n ^ w_v;
         COND_GE: o_taken = ~(w_n ^ w_v);
         COND_CS: o_taken = w_c;
         COND_CC: o_taken = ~w_c;
         default: o_taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/useq_controller.sv
// Hardwired fetch/decode/execute microsequencer with PSR flags and a
// memory-acknowledge watchdog that parks the machine in a terminal fault.
module useq_controller import useq_pkg::*; #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic     USEQ_CLOCK_50,
   input  logic     USEQ_RESET_InLow,
   useq_if.master   bus
);

   state_t     r_state;
   logic [3:0] r_psr;
   logic [7:0] r_wdog;
   logic       r_fault;
   logic       r_illegal;

   logic [1:0] w_op;
   logic [5:0] w_op3;
   logic       w_store;
   logic       w_taken;
   logic       w_req;
   logic       w_ack;

   assign w_op    = bus.USEQ_DecodeOP_InBus[7:6];
   assign w_op3   = bus.USEQ_DecodeOP_InBus[5:0];
   assign w_store = (w_op3 == OP3_ST);

   // Request is gated by reset so an access in flight drops the instant reset asserts.
   assign w_req = ((r_state == ST_FETCH) || (r_state == ST_MEMW)) && USEQ_RESET_InLow;
   assign w_ack = w_req && bus.USEQ_MemAck_In;

   useq_cond_eval u_cond_eval (
      .i_cond  (bus.USEQ_DecodeOP_InBus[4:1]),
      .i_psr   (r_psr),
      .o_taken (w_taken)
   );

   always_ff @(posedge USEQ_CLOCK_50 or negedge USEQ_RESET_InLow) begin
      if (!USEQ_RESET_InLow) begin
         r_state   <= ST_FETCH;
         r_psr     <= 4'b0000;
         r_wdog    <= 8'd0;
         r_fault   <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         r_illegal <= 1'b0;
         case (r_state)
            ST_FETCH, ST_MEMW: begin
               if (w_ack) begin
                  r_wdog  <= 8'd0;
                  r_state <= (r_state == ST_FETCH) ? ST_DECODE : ST_PCINC;
               end else if (r_wdog == 8'(MEM_TIMEOUT - 1)) begin
                  r_wdog  <= 8'd0;
                  r_fault <= 1'b1;
                  r_state <= ST_FAULT;
               end else begin
                  r_wdog <= r_wdog + 8'd1;
               end
            end
            ST_DECODE: begin
               if (w_op == OP_ARITH && is_arith_op3(w_op3))
                  r_state <= ST_EXEC;
               else if (w_op == OP_MEM && (w_op3 == OP3_LD || w_op3 == OP3_ST))
                  r_state <= ST_ADDR;
               else if (w_op == OP_BRANCH)
                  r_state <= ST_BRANCH;
               else begin
                  r_illegal <= 1'b1;
                  r_state   <= ST_PCINC;
               end
            end
            ST_EXEC: begin
               if (w_op3[4])
                  r_psr <= {bus.USEQ_FlagN_In, bus.USEQ_FlagZ_In, bus.USEQ_FlagV_In, bus.USEQ_FlagC_In};
               r_state <= ST_PCINC;
            end
            ST_ADDR:   r_state <= ST_MEMW;
            ST_BRANCH: r_state <= w_taken ? ST_FETCH : ST_PCINC;
            ST_PCINC:  r_state <= ST_FETCH;
            default:   r_state <= ST_FAULT;
         endcase
      end
   end

   always_comb begin
      bus.USEQ_DirA_OutBus         = REG_R0;
      bus.USEQ_DirB_OutBus         = REG_R0;
      bus.USEQ_DirC_OutBus         = REG_R0;
      bus.USEQ_SelectA_Out         = 1'b0;
      bus.USEQ_SelectB_Out         = 1'b0;
      bus.USEQ_SelectC_Out         = 1'b0;
      bus.USEQ_ALUOperation_OutBus = ALU_ADD;
      bus.USEQ_RD_Out              = 1'b0;
      bus.USEQ_MemReq_Out          = 1'b0;
      bus.USEQ_MemWrite_Out        = 1'b0;
      case (r_state)
         ST_FETCH: begin
            bus.USEQ_DirA_OutBus = REG_PC;
            bus.USEQ_SelectA_Out = 1'b1;
            bus.USEQ_MemReq_Out  = w_req;
            if (w_ack) begin
               bus.USEQ_RD_Out      = 1'b1;
               bus.USEQ_DirC_OutBus = REG_IR;
               bus.USEQ_SelectC_Out = 1'b1;
            end
         end
         ST_EXEC: bus.USEQ_ALUOperation_OutBus = alu_code(w_op3);
         ST_ADDR: begin
            bus.USEQ_DirC_OutBus = REG_TEMP;
            bus.USEQ_SelectC_Out = 1'b1;
         end
         ST_MEMW: begin
            bus.USEQ_DirA_OutBus = REG_TEMP;
            bus.USEQ_SelectA_Out = 1'b1;
            bus.USEQ_MemReq_Out  = w_req;
            if (w_store) begin
               bus.USEQ_MemWrite_Out = w_req;
               bus.USEQ_DirB_OutBus  = {1'b0, bus.USEQ_IRrd_InBus};
               bus.USEQ_SelectB_Out  = 1'b1;
            end else if (w_ack) begin
               bus.USEQ_RD_Out = 1'b1;
            end
         end
         ST_BRANCH: begin
            if (w_taken) begin
               bus.USEQ_DirA_OutBus         = REG_PC;
               bus.USEQ_SelectA_Out         = 1'b1;
               bus.USEQ_ALUOperation_OutBus = ALU_ADDD22;
               bus.USEQ_DirC_OutBus         = REG_PC;
               bus.USEQ_SelectC_Out         = 1'b1;
            end
         end
         ST_PCINC: begin
            bus.USEQ_DirA_OutBus         = REG_PC;
            bus.USEQ_SelectA_Out         = 1'b1;
            bus.USEQ_ALUOperation_OutBus = ALU_INC4;
            bus.USEQ_DirC_OutBus         = REG_PC;
            bus.USEQ_SelectC_Out         = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.USEQ_PSR_OutBus  = r_psr;
   assign bus.USEQ_Fault_Out   = r_fault;
   assign bus.USEQ_Illegal_Out = r_illegal;

endmodule

// File: tb/tb_useq_controller.sv
// Directed bench for useq_controller: expected output snapshots are queued
// as each step is driven and popped against the DUT mid-cycle.
module tb_useq_controller;
   import useq_pkg::*;

   typedef struct packed {
      logic [5:0] dir_a;
      logic [5:0] dir_b;
      logic [5:0] dir_c;
      logic       sel_a;
      logic       sel_b;
      logic       sel_c;
      logic [3:0] alu;
      logic       rd;
      logic       req;
      logic       wr;
      logic [3:0] psr;
      logic       fault;
      logic       illegal;
   } outs_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   useq_if bus ();

   useq_controller #(.MEM_TIMEOUT(16)) dut (
      .USEQ_CLOCK_50    (clk),
      .USEQ_RESET_InLow (rst_n),
      .bus              (bus)
   );

   always #5 clk = ~clk;

   outs_t      exp_q[$];
   string      tag_q[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   logic [3:0] m_psr   = 4'b0000;
   logic       m_fault = 1'b0;

   function automatic outs_t sample();
      outs_t o;
      o.dir_a   = bus.USEQ_DirA_OutBus;
      o.dir_b   = bus.USEQ_DirB_OutBus;
      o.dir_c   = bus.USEQ_DirC_OutBus;
      o.sel_a   = bus.USEQ_SelectA_Out;
      o.sel_b   = bus.USEQ_SelectB_Out;
      o.sel_c   = bus.USEQ_SelectC_Out;
      o.alu     = bus.USEQ_ALUOperation_OutBus;
      o.rd      = bus.USEQ_RD_Out;
      o.req     = bus.USEQ_MemReq_Out;
      o.wr      = bus.USEQ_MemWrite_Out;
      o.psr     = bus.USEQ_PSR_OutBus;
      o.fault   = bus.USEQ_Fault_Out;
      o.illegal = bus.USEQ_Illegal_Out;
      return o;
   endfunction

   function automatic outs_t f_idle();
      outs_t o = '0;
      o.psr   = m_psr;
      o.fault = m_fault;
      return o;
   endfunction

   function automatic outs_t f_fetch(input logic ack);
      outs_t o = f_idle();
      o.dir_a = 6'd15;
      o.sel_a = 1'b1;
      o.req   = 1'b1;
      if (ack) begin
         o.rd    = 1'b1;
         o.dir_c = 6'd14;
         o.sel_c = 1'b1;
      end
      return o;
   endfunction

   function automatic outs_t f_exec(input logic [3:0] alu);
      outs_t o = f_idle();
      o.alu = alu;
      return o;
   endfunction

   function automatic outs_t f_addr();
      outs_t o = f_idle();
      o.dir_c = 6'd13;
      o.sel_c = 1'b1;
      return o;
   endfunction

   function automatic outs_t f_memw(input logic store, input logic ack, input logic [4:0] rd);
      outs_t o = f_idle();
      o.dir_a = 6'd13;
      o.sel_a = 1'b1;
      o.req   = 1'b1;
      if (store) begin
         o.wr    = 1'b1;
         o.dir_b = {1'b0, rd};
         o.sel_b = 1'b1;
      end else begin
         o.rd = ack;
      end
      return o;
   endfunction

   function automatic outs_t f_pc_update(input logic [3:0] alu, input logic illegal);
      outs_t o = f_idle();
      o.dir_a   = 6'd15;
      o.sel_a   = 1'b1;
      o.alu     = alu;
      o.dir_c   = 6'd15;
      o.sel_c   = 1'b1;
      o.illegal = illegal;
      return o;
   endfunction

   task automatic push(input string tag, input outs_t e);
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic check();
      outs_t got;
      outs_t e;
      string tag;
      #1;
      got = sample();
      e   = exp_q.pop_front();
      tag = tag_q.pop_front();
      n_tests++;
      assert (got === e) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, e);
      end
   endtask

   task automatic step(input string tag, input outs_t e);
      push(tag, e);
      check();
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_ack(input logic [7:0] op);
      bus.USEQ_MemAck_In     = 1'b1;
      bus.USEQ_DecodeOP_InBus = op;
      step("fetch_ack", f_fetch(1'b1));
      next_cycle();
      bus.USEQ_MemAck_In = 1'b0;
      step("decode", f_idle());
      next_cycle();
   endtask

   initial begin
      bus.USEQ_DecodeOP_InBus = 8'h00;
      bus.USEQ_IR13_In        = 1'b0;
      bus.USEQ_IRrd_InBus     = 5'd0;
      {bus.USEQ_FlagN_In, bus.USEQ_FlagZ_In, bus.USEQ_FlagV_In, bus.USEQ_FlagC_In} = 4'b0000;
      bus.USEQ_MemAck_In      = 1'b0;

      // Reset values: only DirA=PC / SelectA driven, no request even with Ack high.
      bus.USEQ_MemAck_In = 1'b1;
      #2;
      begin
         outs_t r = f_idle();
         r.dir_a = 6'd15;
         r.sel_a = 1'b1;
         step("reset", r);
      end
      bus.USEQ_MemAck_In = 1'b0;
      next_cycle();
      next_cycle();
      rst_n = 1'b1;

      // Fetch with Ack after two waiting cycles, then ADDCC.
      step("fetch_wait0", f_fetch(1'b0));
      next_cycle();
      step("fetch_wait1", f_fetch(1'b0));
      next_cycle();
      {bus.USEQ_FlagN_In, bus.USEQ_FlagZ_In, bus.USEQ_FlagV_In, bus.USEQ_FlagC_In} = 4'b1001;
      fetch_ack(8'h90);
      step("exec_addcc", f_exec(ALU_ADDCC));
      next_cycle();
      m_psr = 4'b1001;
      {bus.USEQ_FlagN_In, bus.USEQ_FlagZ_In, bus.USEQ_FlagV_In, bus.USEQ_FlagC_In} = 4'b0110;
      step("pcinc_addcc", f_pc_update(ALU_INC4, 1'b0));
      next_cycle();

      // Plain ADD must leave PSR untouched.
      fetch_ack(8'h80);
      step("exec_add", f_exec(ALU_ADD));
      next_cycle();
      step("pcinc_add_psr_kept", f_pc_update(ALU_INC4, 1'b0));
      next_cycle();

      // LD with Ack after three waiting cycles.
      fetch_ack(8'hC0);
      step("addr_ld", f_addr());
      next_cycle();
      for (int i = 0; i < 3; i++) begin
         step("memw_ld_wait", f_memw(1'b0, 1'b0, 5'd0));
         next_cycle();
      end
      bus.USEQ_MemAck_In = 1'b1;
      step("memw_ld_ack", f_memw(1'b0, 1'b1, 5'd0));
      next_cycle();
      bus.USEQ_MemAck_In = 1'b0;
      step("pcinc_ld", f_pc_update(ALU_INC4, 1'b0));
      next_cycle();

      // ST of rd=5.
      bus.USEQ_IRrd_InBus = 5'd5;
      fetch_ack(8'hC4);
      step("addr_st", f_addr());
      next_cycle();
      step("memw_st_wait", f_memw(1'b1, 1'b0, 5'd5));
      next_cycle();
      bus.USEQ_MemAck_In = 1'b1;
      step("memw_st_ack", f_memw(1'b1, 1'b1, 5'd5));
      next_cycle();
      bus.USEQ_MemAck_In = 1'b0;
      step("pcinc_st", f_pc_update(ALU_INC4, 1'b0));
      next_cycle();

      // BE with Z=0 falls through to PCINC.
      fetch_ack(8'h02);
      step("branch_be_not_taken", f_idle());
      next_cycle();
      step("pcinc_be", f_pc_update(ALU_INC4, 1'b0));
      next_cycle();

      // ANDCC sets Z, then BE is taken straight back to FETCH.
      {bus.USEQ_FlagN_In, bus.USEQ_FlagZ_In, bus.USEQ_FlagV_In, bus.USEQ_FlagC_In} = 4'b0100;
      fetch_ack(8'h91);
      step("exec_andcc", f_exec(ALU_ANDCC));
      next_cycle();
      m_psr = 4'b0100;
      step("pcinc_andcc", f_pc_update(ALU_INC4, 1'b0));
      next_cycle();
      fetch_ack(8'h02);
      step("branch_be_taken", f_pc_update(ALU_ADDD22, 1'b0));
      next_cycle();
      step("fetch_after_branch", f_fetch(1'b0));

      // Unsupported opcode (op=01) pulses Illegal for exactly one cycle.
      fetch_ack(8'h40);
      step("pcinc_illegal", f_pc_update(ALU_INC4, 1'b1));
      next_cycle();
      step("illegal_cleared", f_fetch(1'b0));

      // Watchdog: 16 unacknowledged request cycles end in FAULT.
      for (int i = 0; i < 16; i++) begin
         step("fetch_timeout_wait", f_fetch(1'b0));
         next_cycle();
      end
      m_fault = 1'b1;
      step("fault_set", f_idle());
      bus.USEQ_MemAck_In = 1'b1;
      next_cycle();
      next_cycle();
      step("fault_ignores_ack", f_idle());
      bus.USEQ_MemAck_In = 1'b0;

      // Reset pulse clears Fault/PSR and restarts fetching.
      rst_n   = 1'b0;
      m_fault = 1'b0;
      m_psr   = 4'b0000;
      begin
         outs_t r = f_idle();
         r.dir_a = 6'd15;
         r.sel_a = 1'b1;
         step("fault_reset", r);
         next_cycle();
         rst_n = 1'b1;
         step("refetch", f_fetch(1'b0));
         next_cycle();
         // Reset mid-request drops Req without waiting for a clock edge.
         rst_n = 1'b0;
         step("reset_mid_access", r);
      end
      rst_n = 1'b1;
      next_cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
